// File: rtl/fsm_rr_arbiter.sv
// fsm_rr_arbiter: four-way round-robin grant FSM with registered one-hot grants and a one-cycle handover gap.
// Optional hold-timeout preemption is built when FSM_RR_TIMEOUT_EN is defined.
module fsm_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       req_2,
  input  logic       req_3,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       gnt_2,
  output logic       gnt_3,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       preempt
);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, RELEASE = 2'b10} state_t;
  state_t state, state_nx;
  logic [3:0] req, gnt, gnt_nx;
  logic [1:0] ptr, ptr_nx, id_nx, win;
  logic found, busy_nx, timeout;
  if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_max_hold
    $error("fsm_rr_arbiter: MAX_HOLD must be in 2..2**CNT_W");
  end
  assign req = {req_3, req_2, req_1, req_0};
  assign {gnt_3, gnt_2, gnt_1, gnt_0} = gnt;
  // rotate the search so the last winner is checked last
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        win = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end
`ifdef FSM_RR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt;
  assign timeout = cnt == CNT_MAX && |(req & ~(4'b0001 << gnt_id));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      preempt <= 1'b0;
    end else begin
      cnt <= (state == GRANT && state_nx == GRANT) ? (cnt == CNT_MAX ? cnt : cnt + 1'b1) : '0;
      preempt <= state == GRANT && req[gnt_id] && timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif
  always_comb begin
    state_nx = IDLE;
    gnt_nx = '0;
    id_nx = gnt_id;
    ptr_nx = ptr;
    busy_nx = 1'b0;
    case (state)
      IDLE, RELEASE: if (found) begin
        state_nx = GRANT;
        gnt_nx = 4'b0001 << win;
        id_nx = win;
        ptr_nx = win;
        busy_nx = 1'b1;
      end
      GRANT: if (!req[gnt_id] || timeout) state_nx = RELEASE;
      else begin
        state_nx = GRANT;
        gnt_nx = gnt;
        busy_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      ptr <= 2'd3;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      gnt_id <= id_nx;
      ptr <= ptr_nx;
      busy <= busy_nx;
    end
  end
endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// tb_fsm_rr_arbiter: directed and randomized checks of fsm_rr_arbiter against a behavioural owner/rotation model.
module tb_fsm_rr_arbiter;
  localparam int MAX_HOLD = 8;
  logic clock = 1'b0, reset = 1'b0;
  logic [3:0] req = '0;
  logic gnt_0, gnt_1, gnt_2, gnt_3, busy, preempt;
  logic [1:0] gnt_id;
  logic [7:0] obs;
  int checks = 0, errors = 0;
  int m_owner, m_last, m_held;
  logic [1:0] m_id;
  logic m_pre;

  fsm_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2), .gnt_3(gnt_3),
    .gnt_id(gnt_id), .busy(busy), .preempt(preempt)
  );

  always #5 clock = ~clock;
  assign obs = {gnt_3, gnt_2, gnt_1, gnt_0, gnt_id, busy, preempt};

  function automatic logic [7:0] expv();
    return {m_owner >= 0 ? 4'(1 << m_owner) : 4'b0000, m_id, m_owner >= 0, m_pre};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_held = 0; m_id = 2'd0; m_pre = 1'b0;
  endtask

  // one clock edge of the arbitration rules: hold, release, preempt or pick next in rotation
  task automatic model_step(input logic [3:0] r);
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) m_owner = -1;
`ifdef FSM_RR_TIMEOUT_EN
      else if (m_held == MAX_HOLD && (r & ~4'(1 << m_owner)) != 4'b0) begin
        m_owner = -1;
        m_pre = 1'b1;
      end
`endif
      else m_held++;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_last = m_owner;
          m_id = 2'(m_owner);
          m_held = 1;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clock);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    model_reset();
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'hF;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset got %h exp %h", obs, 8'h00); end
    @(posedge clock); #1;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_held got %h exp %h", obs, 8'h00); end
    @(negedge clock);
    reset = 1'b0;
    req = '0;
  endtask

  task automatic test_rotation();
    int order[$];
    int expo[5] = '{0, 1, 2, 3, 0};
    logic [3:0] r;
    logic prev_busy;
    do_reset();
    prev_busy = 1'b0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      r = 4'hF;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
      step(r);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL rotation cyc %0d got %h exp %h", c, obs, expv()); end
      if (busy && !prev_busy) order.push_back(int'(gnt_id));
      prev_busy = busy;
    end
    checks++;
    if (order.size() != 5) begin errors++; $display("FAIL rotation_count got %0d exp 5", order.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++;
      if (order[i] != expo[i]) begin errors++; $display("FAIL rotation_order %0d got %0d exp %0d", i, order[i], expo[i]); end
    end
  endtask

  task automatic test_single_pulse();
    int n2 = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(c < 5 ? 4'b0100 : 4'b0000);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL pulse cyc %0d got %h exp %h", c, obs, expv()); end
      if (gnt_2) n2++;
    end
    checks++;
    if (n2 != 5) begin errors++; $display("FAIL pulse_len got %0d exp 5", n2); end
  endtask

  task automatic test_fairness();
    logic [3:0] seq[8] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0001};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(seq[c]);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL fair cyc %0d got %h exp %h", c, obs, expv()); end
      if (c == 5) begin
        checks++;
        if ({gnt_1, gnt_id} !== 3'b101) begin errors++; $display("FAIL fair_winner got gnt_1=%b id=%0d exp gnt_1=1 id=1", gnt_1, gnt_id); end
      end
    end
  endtask

  task automatic test_timeout();
    int n0 = 0, n1 = 0, n3 = 0, np = 0;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      step(4'b1001);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL hold cyc %0d got %h exp %h", c, obs, expv()); end
      n0 += int'(gnt_0); n3 += int'(gnt_3); np += int'(preempt);
    end
`ifdef FSM_RR_TIMEOUT_EN
    checks++;
    if (n0 != 9 || n3 != 8 || np != 2) begin errors++; $display("FAIL timeout_counts got %0d/%0d/%0d exp 9/8/2", n0, n3, np); end
`else
    checks++;
    if (n0 != 19 || n3 != 0 || np != 0) begin errors++; $display("FAIL hold_counts got %0d/%0d/%0d exp 19/0/0", n0, n3, np); end
`endif
    do_reset();
    np = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0010);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL solo cyc %0d got %h exp %h", c, obs, expv()); end
      n1 += int'(gnt_1); np += int'(preempt);
    end
    checks++;
    if (n1 != 20 || np != 0) begin errors++; $display("FAIL solo_counts got %0d/%0d exp 20/0", n1, np); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b1000);
    step(4'b1000);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL areset_pre got %h exp %h", obs, expv()); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({gnt_3, gnt_2, gnt_1, gnt_0, busy} !== 5'b0) begin errors++; $display("FAIL areset_drop got %b exp 00000", {gnt_3, gnt_2, gnt_1, gnt_0, busy}); end
    #3;
    reset = 1'b0;
    step(4'b1000);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL areset_r3 got %h exp %h", obs, expv()); end
    do_reset();
    step(4'b1001);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL areset_r0 got %h exp %h", obs, expv()); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) r[b] = $urandom_range(0, 3) != 0;
      step(r);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random cyc %0d req %b got %h exp %h", c, r, obs, expv()); end
      checks++;
      if (!$onehot0({gnt_3, gnt_2, gnt_1, gnt_0})) begin errors++; $display("FAIL onehot cyc %0d got %b exp onehot0", c, {gnt_3, gnt_2, gnt_1, gnt_0}); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_single_pulse();
    test_fairness();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_rr_arbiter.md
Name: fsm_rr_arbiter

Overview:
- Four-requester round-robin grant controller for a shared resource, in the same request/grant style as the existing fixed-priority grant FSM.
- Fair rotation stops a heavily requesting low index from starving the others.
- Registered one-hot grants.
- Optional hold-timeout preemption.
- One dead cycle between owners so the shared resource can hand over cleanly.

Parameters:
- MAX_HOLD, 8, maximum GRANT cycles before forced release while another requester waits; legal range 2..2^CNT_W.
- CNT_W, 4, width of hold counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_0  input  1  request from requester 0; level, held until done.
- req_1  input  1  request from requester 1.
- req_2  input  1  request from requester 2.
- req_3  input  1  request from requester 3.
- gnt_0  output  1  grant to requester 0, registered.
- gnt_1  output  1  grant to requester 1.
- gnt_2  output  1  grant to requester 2.
- gnt_3  output  1  grant to requester 3.
- gnt_id  output  2  index of current/last owner; valid while busy=1.
- busy  output  1  high while in GRANT.
- preempt  output  1  one-cycle pulse when a grant is removed by timeout.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; gnt_0..3=0; busy=0; preempt=0; gnt_id=0; counter=0.
  - Internal last-winner pointer=3, so index 0 has first priority.
- States:
  - IDLE (2'b00)
  - GRANT (2'b01)
  - RELEASE (2'b10)
  - Encoding 2'b11 is illegal and goes to IDLE with all grants cleared.
- Arbitration (evaluated in IDLE and RELEASE):
  - Search order is ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  - First asserted req wins.
  - On the next edge: state=GRANT, the winner's gnt=1, gnt_id=winner, ptr=winner, counter=0, busy=1.
  - Latency: req high before edge N in IDLE gives gnt high after edge N (one cycle).
  - No req: stay in / go to IDLE, all gnt=0.
- GRANT:
  - Counter increments each cycle and saturates at MAX_HOLD-1.
  - Owner's req=0 at an edge: clear gnt, busy=0, go to RELEASE.
  - Otherwise the grant is held.
  - Requests from non-owners are ignored except for the timeout check.
- RELEASE:
  - Exactly one cycle with all gnt=0 (dead cycle).
  - Arbitration in this cycle decides the next owner. The just-released owner is lowest priority because ptr=owner.
- Grant invariants: at most one gnt high in any cycle. gnt changes only at clock edges.
- Simultaneous events: owner drop and timeout in the same cycle counts as a normal release; preempt stays 0.
- Reset mid-GRANT: grant drops asynchronously. The pointer returns to 3, so rotation history is lost.
- Owner reasserting req in RELEASE: treated as a normal requester at lowest priority. If it is the only requester it wins again.

Optional Feature:
- Macro: FSM_RR_TIMEOUT_EN
- Defined:
  - In GRANT, if counter==MAX_HOLD-1, owner req is still 1, and any other req is 1, then at that edge: clear gnt, go to RELEASE, preempt=1 for one cycle.
  - The owner therefore holds at most MAX_HOLD cycles under contention.
  - With no contention the owner holds indefinitely; the counter stays saturated.
- Undefined:
  - Counter and timeout logic are not built.
  - preempt is tied to 0.
  - The owner holds until its own req drops.
  - MAX_HOLD and CNT_W are unused.

Test Plan:
- Reset then req_0..3=4'b1111 held:
  - Without the macro, each owner drops its req after 3 GRANT cycles. Grant order is 0,1,2,3,0.
  - Each grant lasts 3 cycles with a 1-cycle all-zero gap.
  - gnt_id follows 0,1,2,3.
- Single req_2 pulse of 5 cycles from IDLE:
  - gnt_2 rises one edge after req_2. It stays high until the edge sampling req_2=0.
  - Then one RELEASE cycle, then IDLE. busy mirrors gnt_2.
- Fairness check (no macro): req_0 permanently high, req_1 pulsed.
  - While 0 owns, req_1 raised. When 0 drops for one cycle, 1 wins in RELEASE even though 0 re-requests.
- Macro defined, MAX_HOLD=8: req_0 and req_3 both held high.
  - gnt_0 high exactly 8 cycles, then preempt=1 for one cycle with all gnt=0.
  - Then gnt_3 for 8 cycles, then back to 0.
- Macro defined, only req_1 high for 20 cycles:
  - gnt_1 continuous for the whole interval; preempt never asserts.
- Async reset asserted mid-cycle while gnt_3=1:
  - All gnt and busy go 0 before the next clock edge.
  - After release with req_0..3=4'b1000, gnt_3 is granted. With 4'b1001, gnt_0 is granted (pointer=3).
